// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared constants and FSM state encoding for the UART Tx frame arbiter.
// Combinational content only: no latency, no handshake.
package uart_arb_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int IDX_W_DEF      = 2;
  localparam int ADDR_W_DEF     = 8;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int GAP_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_frame_arbiter_if.sv
// Requester/engine-facing bundle of the frame arbiter; master = arbiter side.
// Latency and backpressure are defined by the arbiter, not by this bundle.
interface uart_arb_if #(
  parameter int N_REQ  = uart_arb_pkg::N_REQ_DEF,
  parameter int IDX_W  = uart_arb_pkg::IDX_W_DEF,
  parameter int ADDR_W = uart_arb_pkg::ADDR_W_DEF
) ();

  logic [N_REQ-1:0]        REQ_ARB_req;
  logic [N_REQ-1:0]        REQ_ARB_empty;
  logic [N_REQ*ADDR_W-1:0] REQ_ARB_addr;
  logic                    USR_ARB_cts;
  logic                    PROT_ARB_tx_r_en;
  logic                    PROT_ARB_frame_done;
  logic [N_REQ-1:0]        ARB_REQ_gnt;
  logic [N_REQ-1:0]        ARB_REQ_r_en;
  logic                    ARB_PROT_Txen;
  logic                    ARB_PROT_empty;
  logic [ADDR_W-1:0]       ARB_PROT_addr;
  logic                    ARB_busy;
  logic [IDX_W-1:0]        ARB_owner;

  modport master (
    input  REQ_ARB_req, REQ_ARB_empty, REQ_ARB_addr, USR_ARB_cts,
    input  PROT_ARB_tx_r_en, PROT_ARB_frame_done,
    output ARB_REQ_gnt, ARB_REQ_r_en, ARB_PROT_Txen, ARB_PROT_empty,
    output ARB_PROT_addr, ARB_busy, ARB_owner
  );

  modport slave (
    output REQ_ARB_req, REQ_ARB_empty, REQ_ARB_addr, USR_ARB_cts,
    output PROT_ARB_tx_r_en, PROT_ARB_frame_done,
    input  ARB_REQ_gnt, ARB_REQ_r_en, ARB_PROT_Txen, ARB_PROT_empty,
    input  ARB_PROT_addr, ARB_busy, ARB_owner
  );

endinterface

// File: rtl/uart_tx_frame_arbiter_rr_picker.sv
// Circular first-set search from start_i: one-hot grant plus index, pure combinational.
// Zero latency; no handshake, the caller decides when to sample the result.
module uart_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             vld_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    vld_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // Extra bit keeps the wrap test exact for non-power-of-two N_REQ.
      cand = {1'b0, start_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!vld_o && req_i[cand[IDX_W-1:0]]) begin
        vld_o                  = 1'b1;
        idx_o                  = cand[IDX_W-1:0];
        gnt_o[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Whole-frame arbiter in front of the UART Tx engine; request to Txen is 2 cycles, guard gap after each frame.
// New grants stall while CTS is low or a frame/gap is in progress; UART_ARB_FIXED_PRIO_EN selects fixed priority.
module uart_tx_frame_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input logic        glb_clk,
  input logic        glb_rst,
  uart_arb_if.master arb_if
);

  arb_state_e           state_q;
  logic [N_REQ-1:0]     gnt_q;
  logic                 txen_q;
  logic                 busy_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;

  logic [IDX_W-1:0]     start_d;
  logic                 pick_vld;
  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 frame_end;

  assign frame_end = (state_q == ACTIVE) && arb_if.PROT_ARB_frame_done;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign start_d = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  assign rr_ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + IDX_W'(1);
  assign start_d  = rr_ptr_q;

  always_ff @(posedge glb_clk or posedge glb_rst) begin
    if (glb_rst)        rr_ptr_q <= '0;
    else if (frame_end) rr_ptr_q <= rr_ptr_d;
  end
`endif

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (arb_if.REQ_ARB_req),
    .start_i (start_d),
    .vld_o   (pick_vld),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge glb_clk or posedge glb_rst) begin
    if (glb_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      txen_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      owner_q   <= '0;
      gap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld && arb_if.USR_ARB_cts) begin
            state_q <= GRANT;
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
            addr_q  <= arb_if.REQ_ARB_addr[pick_idx*ADDR_W +: ADDR_W];
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          state_q <= ACTIVE;
          txen_q  <= 1'b1;
        end
        ACTIVE: begin
          // Txen drops with the grant so the engine idles in INIT instead of restarting.
          if (arb_if.PROT_ARB_frame_done) begin
            state_q   <= GAP;
            txen_q    <= 1'b0;
            gnt_q     <= '0;
            gap_cnt_q <= GAP_CNT_W'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_if.ARB_REQ_gnt    = gnt_q;
  assign arb_if.ARB_REQ_r_en   = ((state_q == ACTIVE) && arb_if.PROT_ARB_tx_r_en) ? gnt_q : '0;
  assign arb_if.ARB_PROT_Txen  = txen_q;
  assign arb_if.ARB_PROT_empty = ((state_q == GRANT) || (state_q == ACTIVE)) ?
                                 arb_if.REQ_ARB_empty[owner_q] : 1'b1;
  assign arb_if.ARB_PROT_addr  = addr_q;
  assign arb_if.ARB_busy       = busy_q;
  assign arb_if.ARB_owner      = owner_q;

endmodule

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
Shares the single UART protocol-layer Tx frame engine (address frame, data frames, stop frame) between N_REQ independent transmit requesters, each with its own Tx FIFO and slave address. Grants whole frames, never individual bytes. Drives the engine's Txen/empty/address inputs from the owner, routes the engine's FIFO read strobe back to that owner's FIFO, and enforces an inter-frame guard gap. Sits between the per-channel config/FIFO blocks and the protocol Tx state machine.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, owner index width, equal to clog2(N_REQ)
ADDR_W, 8, slave address width
GAP_CYCLES, 2, idle cycles enforced after each frame (1..255)

Ports:
glb_clk  in  1  system clock, rising edge
glb_rst  in  1  asynchronous reset, active-high
REQ_ARB_req  in  N_REQ  per-requester frame request, level
REQ_ARB_empty  in  N_REQ  per-requester Tx FIFO empty
REQ_ARB_addr  in  N_REQ*ADDR_W  per-requester slave address, packed, requester 0 in LSBs
USR_ARB_cts  in  1  clear-to-send from far end
PROT_ARB_tx_r_en  in  1  FIFO read strobe from protocol engine
PROT_ARB_frame_done  in  1  one-cycle pulse when the stop frame is consumed
ARB_REQ_gnt  out  N_REQ  one-hot grant, held for the whole frame
ARB_REQ_r_en  out  N_REQ  read strobe routed to owner FIFO
ARB_PROT_Txen  out  1  frame enable to protocol engine
ARB_PROT_empty  out  1  owner FIFO empty, muxed
ARB_PROT_addr  out  ADDR_W  owner slave address, latched
ARB_busy  out  1  high in any state other than IDLE
ARB_owner  out  IDX_W  index of current or last owner

Behaviour:
- Reset: state IDLE; gnt=0, r_en=0, Txen=0, empty=1, addr=0, busy=0, owner=0, rr_ptr=0, gap counter=0. Reset mid-frame aborts immediately with no pending state kept.
- States: IDLE, GRANT, ACTIVE, GAP.
- IDLE -> GRANT when (|REQ_ARB_req) && USR_ARB_cts. Round-robin selection starts at rr_ptr and wraps at N_REQ-1 -> 0. Owner index and address are latched on this edge. gnt is registered and goes high on entry to GRANT.
- GRANT -> ACTIVE unconditionally after 1 cycle. Address and mux are stable before Txen rises.
- ACTIVE: Txen=1 (registered). empty = REQ_ARB_empty[owner]. ARB_REQ_r_en[owner] = PROT_ARB_tx_r_en, combinational; all other r_en bits are 0. ACTIVE -> GAP on PROT_ARB_frame_done.
- GAP: Txen=0 and gnt=0 on entry, so the engine sees Txen low when it returns to INIT and does not restart. empty=1. The counter loads GAP_CYCLES-1 and counts down. GAP -> IDLE when the counter reaches 0. rr_ptr = owner+1 (mod N_REQ) on GAP entry.
- Request arrival to Txen high: 2 cycles minimum.
- Owner deasserting req mid-frame is ignored; the frame runs to done.
- A CTS drop during ACTIVE is ignored and left to the protocol layer. It only blocks new grants.
- PROT_ARB_tx_r_en outside ACTIVE is dropped.
- PROT_ARB_frame_done outside ACTIVE is ignored.
- Simultaneous requests: exactly one grant, and no requester waits more than N_REQ-1 frames.
- Invalid requester index (index >= N_REQ) is never selected.

Optional Feature:
UART_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above.

Decomposition:
- Package uart_arb_pkg holds the state enum encodings (IDLE=0, GRANT=1, ACTIVE=2, GAP=3) and the default parameter constants.
- One sub-module, uart_rr_picker: combinational request vector + start pointer -> one-hot grant and index. Reused for fixed priority with the pointer tied to 0.

Test Plan:
- Single requester: req[1]=1, addr1=0x5A, cts=1 -> gnt=0010 at t+1, Txen=1 at t+2, ARB_PROT_addr=0x5A; 3 tx_r_en pulses reach r_en[1] only; frame_done -> Txen=0 next cycle, IDLE after 2 GAP cycles.
- All four requesting continuously -> owners 0,1,2,3,0 in order. With UART_ARB_FIXED_PRIO_EN: owner 0 every frame.
- cts=0 with req=1111 -> no grant, busy=0. cts rises -> grant within 1 cycle.
- Owner drops req mid-ACTIVE -> gnt held until frame_done, Txen stays 1.
- glb_rst pulsed during ACTIVE -> all outputs return to reset values asynchronously; after release with req[2]=1, the first grant goes to requester 2.
- Stray frame_done and tx_r_en pulses in IDLE/GAP -> no r_en output and no state change.
